// File: rtl/dco_nco_bank.sv
// dco_nco_bank: a bank of independent numerically controlled oscillators.
// Each channel adds its active frequency code to a phase accumulator every
// enabled cycle. A newly written code waits in a pending register and is
// only adopted at the channel's next phase wrap, or immediately if the
// channel is stopped. Outputs are registered and selected by a global mode.
module dco_nco_bank #(
   parameter int CODE_W = 8,
   parameter int ACC_W  = 16,
   parameter int NCH    = 2,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CODE_W-1:0] wr_code,
   input  logic [1:0]        mode,
   output logic [NCH-1:0]    dco_out,
   output logic [NCH-1:0]    wrap,
   output logic [NCH-1:0]    pend
);

   localparam logic [1:0] MODE_SQUARE = 2'b00;
   localparam logic [1:0] MODE_PULSE  = 2'b01;
   localparam logic [1:0] MODE_DIV2   = 2'b10;
   localparam logic [1:0] MODE_MUTE   = 2'b11;

   logic [ACC_W-1:0]  acc_r  [NCH];
   logic [CODE_W-1:0] cur_r  [NCH];
   logic [CODE_W-1:0] nxt_r  [NCH];
   logic [NCH-1:0]    pend_r;
   logic [NCH-1:0]    tog_r;
   logic [NCH-1:0]    wrap_r;
   logic [NCH-1:0]    dco_r;

   logic [ACC_W:0]    sum_s  [NCH];
   logic [NCH-1:0]    carry_s;
   logic [NCH-1:0]    wr_hit_s;
   logic [NCH-1:0]    apply_s;
   logic [NCH-1:0]    dco_sel_s;

   // Per-channel next-phase sum, wrap detection, write decode and apply decision.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         sum_s[i]    = {1'b0, acc_r[i]} + {{(ACC_W + 1 - CODE_W){1'b0}}, cur_r[i]};
         carry_s[i]  = ena & sum_s[i][ACC_W];
         // Indices >= NCH never match any channel, so such writes are dropped.
         wr_hit_s[i] = wr_en & (int'(wr_ch) == i);
         // A stopped channel never wraps, so it adopts a pending code at once.
         if (cur_r[i] == {CODE_W{1'b0}}) begin
            apply_s[i] = pend_r[i];
         end else begin
            apply_s[i] = pend_r[i] & carry_s[i];
         end
      end
   end

   // Output source selection from the registered phase, wrap and toggle state.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         case (mode)
            MODE_SQUARE: dco_sel_s[i] = acc_r[i][ACC_W-1];
            MODE_PULSE:  dco_sel_s[i] = wrap_r[i];
            MODE_DIV2:   dco_sel_s[i] = tog_r[i];
            MODE_MUTE:   dco_sel_s[i] = 1'b0;
            default:     dco_sel_s[i] = 1'b0;
         endcase
      end
   end

   // Phase accumulators, divide-by-2 toggles and the one-cycle wrap pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            acc_r[i] <= {ACC_W{1'b0}};
         end
         tog_r  <= {NCH{1'b0}};
         wrap_r <= {NCH{1'b0}};
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (ena) begin
               acc_r[i] <= sum_s[i][ACC_W-1:0];
               tog_r[i] <= tog_r[i] ^ carry_s[i];
            end
            // carry_s is already gated by ena, so a frozen bank shows no wraps.
            wrap_r[i] <= carry_s[i];
         end
      end
   end

   // Active/pending code registers; a write on an apply cycle stays pending.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            cur_r[i] <= {CODE_W{1'b0}};
            nxt_r[i] <= {CODE_W{1'b0}};
         end
         pend_r <= {NCH{1'b0}};
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (apply_s[i]) begin
               cur_r[i] <= nxt_r[i];
            end
            if (wr_hit_s[i]) begin
               nxt_r[i] <= wr_code;
            end
            pend_r[i] <= wr_hit_s[i] | (pend_r[i] & ~apply_s[i]);
         end
      end
   end

   // Registered oscillator outputs; frozen while the bank is disabled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dco_r <= {NCH{1'b0}};
      end else if (ena) begin
         dco_r <= dco_sel_s;
      end else begin
         dco_r <= dco_r;
      end
   end

   assign dco_out = dco_r;
   assign wrap    = wrap_r;
   assign pend    = pend_r;

endmodule

// File: tb/tb_dco_nco_bank.sv
// Directed testbench for dco_nco_bank. Three channels are instantiated so
// that an out-of-range write index exists. Event times are measured in
// cycles relative to a reference point and compared with hand-computed values.
module tb_dco_nco_bank;

   localparam int CODE_W = 8;
   localparam int ACC_W  = 16;
   localparam int NCH    = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [7:0]  wr_code;
   logic [1:0]  mode;
   logic [2:0]  dco_out;
   logic [2:0]  wrap;
   logic [2:0]  pend;

   int cyc   = 0;
   int n_chk = 0;
   int n_err = 0;
   int base  = 0;
   int t     = 0;
   int bad   = 0;

   dco_nco_bank #(.CODE_W(CODE_W), .ACC_W(ACC_W), .NCH(NCH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .wr_en   (wr_en),
      .wr_ch   (wr_ch),
      .wr_code (wr_code),
      .mode    (mode),
      .dco_out (dco_out),
      .wrap    (wrap),
      .pend    (pend)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic write_code(input logic [1:0] ch, input logic [7:0] code);
      wr_en   = 1'b1;
      wr_ch   = ch;
      wr_code = code;
      tick();
      wr_en   = 1'b0;
   endtask

   // kind 0: wrap pulse, 1: dco rising edge, 2: dco falling edge.
   // Returns -1 when the bound expires, which makes the caller's check fail.
   task automatic wait_ev(input int ch, input int kind, input int limit, output int t_ev);
      logic prev;
      t_ev = -1;
      for (int i = 0; i < limit; i++) begin
         prev = dco_out[ch];
         tick();
         if ((kind == 0 && wrap[ch]) ||
             (kind == 1 && !prev && dco_out[ch]) ||
             (kind == 2 && prev && !dco_out[ch])) begin
            t_ev = cyc;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_code = 8'h00; mode = 2'b00;
      tick(); tick();
      check("rst_dco",  dco_out, 3'b000);
      check("rst_wrap", wrap,    3'b000);
      check("rst_pend", pend,    3'b000);
      rst_n = 1'b1; ena = 1'b1;
      tick();

      // Square wave, code 0x80: period 512, 256 high.
      write_code(2'd0, 8'h80);
      check("pend_set", pend, 3'b001);
      tick();
      check("pend_clr", pend, 3'b000);
      base = cyc;
      wait_ev(0, 1, 600, t);  check("sq_rise",     t - base, 257);
      wait_ev(0, 0, 600, t);  check("wrap_first",  t - base, 512);
      wait_ev(0, 2, 600, t);  check("sq_fall",     t - base, 513);
      wait_ev(0, 1, 600, t);  check("sq_period",   t - base, 769);
      wait_ev(0, 0, 600, t);  check("wrap_period", t - base, 1024);
      tick();
      check("wrap_pulse", wrap, 3'b000);

      // Mid-period rewrite to 0x40: applied at the wrap, then period 1024.
      goto(base + 1124);
      write_code(2'd0, 8'h40);
      check("pend_mid", pend, 3'b001);
      goto(base + 1535);
      check("pend_hold", pend, 3'b001);
      tick();
      check("apply_wrap", wrap, 3'b001);
      check("apply_pend", pend, 3'b000);
      wait_ev(0, 2, 600,  t); check("sw_fall", t - base, 1537);
      wait_ev(0, 1, 1100, t); check("sw_rise", t - base, 2049);
      wait_ev(0, 0, 1100, t); check("sw_wrap", t - base, 2560);
      wait_ev(0, 2, 600,  t); check("sw_high", t - base, 2561);

      // Back-to-back writes, then a write landing on the wrap cycle.
      goto(base + 2998);
      write_code(2'd0, 8'h30);
      write_code(2'd0, 8'h20);
      check("b2b_pend", pend, 3'b001);
      goto(base + 3583);
      write_code(2'd0, 8'h10);
      check("wc_wrap", wrap, 3'b001);
      check("wc_pend", pend, 3'b001);
      wait_ev(0, 0, 2100, t); check("older_applied", t - base, 5632);
      check("last_pend_clr", pend, 3'b000);
      wait_ev(0, 0, 4200, t); check("last_applied", t - base, 9728);

      // Freeze for 100 cycles mid-period with dco high.
      goto(base + 12228);
      check("pre_freeze", dco_out, 3'b001);
      ena = 1'b0;
      write_code(2'd3, 8'h55);
      check("bad_ch_ignored", pend, 3'b000);
      write_code(2'd1, 8'h10);
      check("stopped_pend", pend, 3'b010);
      tick();
      check("stopped_apply", pend, 3'b000);
      bad = 0;
      while (cyc < base + 12328) begin
         tick();
         if (dco_out !== 3'b001 || wrap !== 3'b000) bad++;
      end
      check("freeze", bad, 0);
      ena = 1'b1;
      wait_ev(0, 0, 2000, t); check("resume_phase", t - base, 13924);

      // Reset while a code is pending.
      write_code(2'd0, 8'h44);
      check("pre_rst_pend", pend, 3'b001);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_dco",  dco_out, 3'b000);
      check("mid_rst_wrap", wrap,    3'b000);
      check("mid_rst_pend", pend,    3'b000);
      bad = 0;
      repeat (600) begin
         tick();
         if (dco_out !== 3'b000 || wrap !== 3'b000 || pend !== 3'b000) bad++;
      end
      check("stay_stopped", bad, 0);

      // Divide-by-2 with ch0=0x01 and ch1=0xFF; then mode changes on the fly.
      mode = 2'b10;
      write_code(2'd0, 8'h01);
      write_code(2'd1, 8'hFF);
      base = cyc;
      wait_ev(1, 0, 400, t); check("ch1_wrap1", t - base, 259);
      check("ch0_no_wrap", wrap, 3'b010);
      wait_ev(1, 1, 400, t); check("div_rise1", t - base, 260);
      wait_ev(1, 0, 400, t); check("ch1_wrap2", t - base, 516);
      wait_ev(1, 2, 400, t); check("div_fall",  t - base, 517);
      wait_ev(1, 0, 400, t); check("ch1_wrap3", t - base, 773);
      wait_ev(1, 1, 400, t); check("div_rise2", t - base, 774);
      mode = 2'b01;
      wait_ev(1, 0, 400, t); check("ch1_wrap4", t - base, 1030);
      tick();
      check("pulse_hi", dco_out, 3'b010);
      tick();
      check("pulse_lo", dco_out, 3'b000);
      mode = 2'b11;
      wait_ev(1, 0, 400, t); check("ch1_wrap5", t - base, 1287);
      tick();
      check("muted", dco_out, 3'b000);
      mode = 2'b10;
      tick();
      check("div_resume", dco_out, 3'b010);
      wait_ev(1, 0, 400, t); check("no_acc_reset", t - base, 1544);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dco_nco_bank.md
DCO_NCO_BANK -- requirements
Module: dco_nco_bank

Interface
REQ-001 SHALL have parameter CODE_W, default 8, the width of the frequency control word per channel.
REQ-002 SHALL have parameter ACC_W, default 16, the phase accumulator width, with ACC_W > CODE_W.
REQ-003 SHALL have parameter NCH, default 2, the number of independent oscillator channels, with NCH >= 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port ena, input, 1 bit: global run enable.
REQ-007 SHALL have port wr_en, input, 1 bit: code write strobe, sampled on clk.
REQ-008 SHALL have port wr_ch, input, max(1,$clog2(NCH)) bits: target channel index.
REQ-009 SHALL have port wr_code, input, CODE_W bits: new frequency code.
REQ-010 SHALL have port mode, input, 2 bits: output mode, global to all channels.
REQ-011 SHALL have port dco_out, output, NCH bits: registered oscillator output per channel.
REQ-012 SHALL have port wrap, output, NCH bits: one-cycle registered pulse per accumulator overflow.
REQ-013 SHALL have port pend, output, NCH bits: high while a written code awaits application.

Function
REQ-014 SHALL keep, per channel, an ACC_W-bit accumulator acc, an active code cur, a pending code nxt and a pending flag.
REQ-015 SHALL, with ena=1, update every channel each cycle as acc <= acc + zero-extended cur, modulo 2^ACC_W.
REQ-016 SHALL treat a carry out of that addition as a wrap event and drive wrap[ch]=1 in the following cycle only.
REQ-017 SHALL give an output frequency of f_clk*cur/2^ACC_W; cur=0 stops the channel with acc held.
REQ-018 SHALL, on wr_en=1 with wr_ch<NCH, load nxt[wr_ch] <= wr_code and set pend[wr_ch]; writes with wr_ch>=NCH SHALL be ignored.
REQ-019 SHALL apply a pending code (cur <= nxt, pend cleared) only on a wrap-event cycle of that channel, so the frequency changes glitch-free at phase zero.
REQ-020 SHALL apply a pending code on the next cycle when cur=0, because a stopped channel never wraps.
REQ-021 SHALL, for a write landing on a channel's apply cycle, apply the older nxt and keep the new value pending (pend stays 1).
REQ-022 SHALL, for a write while pend=1, overwrite nxt without applying it.
REQ-023 SHALL, with ena=0, hold acc, cur, dco_out and toggle state, force wrap=0, and still accept writes; applies then take place only when cur=0.
REQ-024 SHALL select dco_out per mode, registered with 1-cycle latency from acc/wrap:
  - 00 square: acc MSB
  - 01 pulse: wrap event
  - 10 divide-by-2: toggle flop flips on each wrap event
  - 11 muted: 0
REQ-025 SHALL let a mode change take effect on the next cycle without resetting acc.

Reset
REQ-026 SHALL, on a clk edge with rst_n=0, clear every acc, cur, nxt, pend, toggle flop, dco_out and wrap to 0, overriding ena and wr_en.
REQ-027 SHALL, on reset asserted mid-operation, abort pending codes; after rst_n=1 all channels are stopped until written.

Verification
REQ-028 SHALL cover: defaults, mode=00, write ch0 code 0x80, ena=1 -> pend[0] high one cycle, then dco_out[0] square with period 512 cycles, 256 high, and wrap[0] every 512 cycles.
REQ-029 SHALL cover: ch0 running 0x80; write 0x40 mid-period -> pend[0] high until the next wrap, then period becomes 1024 with no short or long half-cycle.
REQ-030 SHALL cover: ch0=0x01, ch1=0xFF, mode=10 -> dco_out[0] period 131072, dco_out[1] period 2*ceil-pattern of 65536/255, independent wraps.
REQ-031 SHALL cover: write during the wrap cycle, and two back-to-back writes -> older value applied at wrap, last value pending and applied at the following wrap.
REQ-032 SHALL cover: ena=0 for 100 cycles mid-period -> outputs frozen and wrap=0; resume continues the same phase; write to wr_ch=NCH ignored.
REQ-033 SHALL cover: rst_n=0 for one cycle while running with pend=1 -> all outputs 0 next cycle, pend cleared, channels stopped.
